// File: rtl/pulse_table_reader.sv
// Walks the pulse-table BRAM from a base index at a fixed stride and streams the words out through a prefetch FIFO.
// Optional build macro PULSE_READER_LOOP_EN adds a `loop` input for endless repeating runs.
module pulse_table_reader #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8000,
    parameter int STRIDE     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [CNT_W-1:0]  count,
`ifdef PULSE_READER_LOOP_EN
    input  logic              loop,
`endif
    input  logic              abort,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [31:0]       bram_addra,
    output logic [31:0]       bram_dina,
    input  logic [DATA_W-1:0] bram_douta,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        addr_r, base_r;
    logic [CNT_W-1:0]   rem_r, cmd_cnt_r;
    logic               valid_d_r, last_d_r;
    logic               done_r, err_r;
    logic [DATA_W:0]    mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     occ_r;

    logic               start_ok_s, go_s, zero_s, bad_s;
    logic               issue_s, last_issue_s, loop_run_s;
    logic [PTR_W+1:0]   occ_sum_s;
    logic               fifo_empty_s, m_valid_s, push_s, pop_s, beat_last_s;
    logic [DATA_W:0]    head_s;

    // Next word index along the table, folded back into 0..DEPTH-1.
    function automatic logic [31:0] next_addr(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = cur + 32'(STRIDE);
        if (nxt >= 32'(DEPTH)) begin
            nxt = nxt - 32'(DEPTH);
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

`ifdef PULSE_READER_LOOP_EN
    logic loop_r;
    assign loop_run_s = loop_r;
`else
    assign loop_run_s = 1'b0;
`endif

    // Start command decode.
    always_comb begin
        start_ok_s = (state_r == ST_IDLE) && start && !abort;
        zero_s     = start_ok_s && (count == CNT_W'(0));
        bad_s      = start_ok_s && (count != CNT_W'(0)) && (base_addr >= 32'(DEPTH));
        go_s       = start_ok_s && (count != CNT_W'(0)) && (base_addr < 32'(DEPTH));
    end

    // Read issue: stored entries plus the word on the BRAM bus must leave a free slot.
    always_comb begin
        occ_sum_s    = (PTR_W+2)'(occ_r) + (PTR_W+2)'(valid_d_r);
        issue_s      = (state_r == ST_READ) && !abort && (occ_sum_s < (PTR_W+2)'(FIFO_DEPTH));
        last_issue_s = (rem_r == CNT_W'(1));
    end

    // FIFO head with fall-through of the returning BRAM word when the FIFO is empty.
    always_comb begin
        fifo_empty_s = (occ_r == (PTR_W+1)'(0));
        if (fifo_empty_s) begin
            head_s = {last_d_r, bram_douta};
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
        m_valid_s   = !fifo_empty_s || valid_d_r;
        pop_s       = !fifo_empty_s && m_ready;
        push_s      = valid_d_r && !(fifo_empty_s && m_ready);
        beat_last_s = m_valid_s && m_ready && head_s[DATA_W];
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (issue_s && last_issue_s && !loop_run_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (abort || beat_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run address/count tracking, read pipeline tag and status pulses.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            addr_r    <= 32'd0;
            base_r    <= 32'd0;
            rem_r     <= CNT_W'(0);
            cmd_cnt_r <= CNT_W'(0);
            valid_d_r <= 1'b0;
            last_d_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
`ifdef PULSE_READER_LOOP_EN
            loop_r    <= 1'b0;
`endif
        end else begin
            valid_d_r <= issue_s;
            last_d_r  <= issue_s && last_issue_s;
            done_r    <= zero_s || ((state_r == ST_DRAIN) && !abort && beat_last_s);
            err_r     <= bad_s;
            if (go_s) begin
                addr_r    <= base_addr;
                base_r    <= base_addr;
                rem_r     <= count;
                cmd_cnt_r <= count;
`ifdef PULSE_READER_LOOP_EN
                loop_r    <= loop;
`endif
            end else if (issue_s) begin
                if (last_issue_s && loop_run_s) begin
                    addr_r <= base_r;
                    rem_r  <= cmd_cnt_r;
                end else begin
                    addr_r <= next_addr(addr_r);
                    rem_r  <= rem_r - CNT_W'(1);
                end
            end
        end
    end

    // FIFO pointers and occupancy; abort flushes everything still queued.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            occ_r    <= (PTR_W+1)'(0);
        end else if (abort) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            occ_r    <= (PTR_W+1)'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + (PTR_W+1)'(1);
                2'b01:   occ_r <= occ_r - (PTR_W+1)'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clka) begin
        if (push_s && !abort) begin
            mem_r[wr_ptr_r] <= {last_d_r, bram_douta};
        end
    end

    assign bram_ena   = issue_s;
    assign bram_wea   = 1'b0;
    assign bram_addra = addr_r;
    assign bram_dina  = 32'h0000_0000;
    assign m_valid    = m_valid_s;
    assign m_data     = m_valid_s ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign m_last     = m_valid_s & head_s[DATA_W];
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_pulse_table_reader.sv
// Scoreboard bench for pulse_table_reader: directed runs with hand-computed addresses and sample words.
module tb_pulse_table_reader;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] count = 16'd0;
    logic        abort = 1'b0;
    logic        bram_ena, bram_wea;
    logic [31:0] bram_addra, bram_dina;
    logic [31:0] bram_douta = 32'd0;
    logic [31:0] m_data;
    logic        m_valid, m_last, busy, done, err;
    logic        m_ready;
    logic        rdy_man = 1'b1;
    logic        bp_mode = 1'b0;
    logic [1:0]  bp_idx = 2'd0;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic [31:0] addr_q[$];
    logic        sb_en = 1'b1;
    logic        addr_chk_en = 1'b1;
    int done_cnt = 0, err_cnt = 0, ena_cnt = 0;
    int issued = 0, hs = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = 33'd0;

    pulse_table_reader dut (
        .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .count(count),
        .abort(abort), .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dina(bram_dina), .bram_douta(bram_douta), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clka = ~clka;

    // Ready pattern 1,0,0,1 repeating in backpressure mode
    assign m_ready = bp_mode ? ((bp_idx == 2'd0) || (bp_idx == 2'd3)) : rdy_man;
    always @(posedge clka) bp_idx <= bp_idx + 2'd1;

    // BRAM preloaded with word i = 0xA000_0000 + i, one-cycle read latency
    always @(posedge clka) if (bram_ena) bram_douta <= 32'hA000_0000 + bram_addra;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: address and beat scoreboards, hold stability, outstanding bound
    always @(negedge clka) begin
        if (!rsta) begin
            if (!busy) begin
                issued = 0;
                hs = 0;
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (bram_ena) begin
                ena_cnt++;
                issued++;
                chk("outstanding_le_4", 64'(issued - hs <= 4), 64'd1);
                if (addr_chk_en) begin
                    if (addr_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
                    else chk("bram_addra", 64'(bram_addra), 64'(addr_q.pop_front()));
                end
            end
            if (prev_stall && m_valid) chk("hold_stable", 64'({m_last, m_data}), 64'(prev_beat));
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
            if (m_valid && m_ready) begin
                hs++;
                if (sb_en) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", 64'({m_last, m_data}), 64'd0);
                    else chk("beat_last_data", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clka);
            #1;
        end
    endtask

    task automatic issue_start(input logic [31:0] b, input logic [15:0] c);
        base_addr = b;
        count = c;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n = 0;
        while (busy && n < max) begin
            cyc(1);
            n++;
        end
        chk(nm, 64'(busy), 64'd0);
    endtask

    task automatic run_basic();
        int d0;
        d0 = done_cnt;
        addr_q.push_back(32'd0); addr_q.push_back(32'd4); addr_q.push_back(32'd8);
        exp_q.push_back({1'b0, 32'hA000_0000});
        exp_q.push_back({1'b0, 32'hA000_0004});
        exp_q.push_back({1'b1, 32'hA000_0008});
        issue_start(32'd0, 16'd3);                     // now cycle N+1
        chk("lat_ena_n1", 64'(bram_ena), 64'd1);
        chk("busy_n1", 64'(busy), 64'd1);
        cyc(1);                                        // N+2
        chk("lat_valid_n2", 64'({m_valid, m_data}), {31'd0, 1'b1, 32'hA000_0000});
        cyc(2);                                        // N+4
        chk("last_n4", 64'(m_last), 64'd1);
        cyc(1);                                        // N+5
        chk("done_n5", 64'({done, busy}), 64'b10);
        cyc(1);
        chk("done_once", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0, e0, n0;
        cyc(2);
        chk("rst_ena", 64'(bram_ena), 64'd0);
        chk("rst_stream", 64'({m_valid, m_last, m_data}), 64'd0);
        chk("rst_status", 64'({busy, done, err}), 64'd0);
        chk("rst_addr", 64'(bram_addra), 64'd0);
        rsta = 1'b0;
        cyc(2);

        // Basic run
        run_basic();

        // Wrap at the end of the table
        d0 = done_cnt;
        addr_q.push_back(32'd7996); addr_q.push_back(32'd0); addr_q.push_back(32'd4);
        exp_q.push_back({1'b0, 32'hA000_1F3C});
        exp_q.push_back({1'b0, 32'hA000_0000});
        exp_q.push_back({1'b1, 32'hA000_0004});
        issue_start(32'd7996, 16'd3);
        wait_idle(50, "wrap_idle");
        cyc(1);
        chk("wrap_done", 64'(done_cnt - d0), 64'd1);

        // Backpressure: base 100 count 10, words 0xA0000064 + 4k
        bp_mode = 1'b1;
        for (int k = 0; k < 10; k++) begin
            addr_q.push_back(32'd100 + 32'(4 * k));
            exp_q.push_back({(k == 9), 32'hA000_0064 + 32'(4 * k)});
        end
        issue_start(32'd100, 16'd10);
        wait_idle(200, "bp_idle");
        bp_mode = 1'b0;
        cyc(1);

        // count=0 -> done only
        n0 = ena_cnt; d0 = done_cnt;
        issue_start(32'd0, 16'd0);
        chk("zero_done", 64'({done, busy}), 64'b10);
        cyc(3);
        chk("zero_no_reads", 64'(ena_cnt - n0), 64'd0);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

        // base out of range -> err
        n0 = ena_cnt; e0 = err_cnt;
        issue_start(32'd8000, 16'd5);
        chk("bad_err", 64'({err, busy, done}), 64'b100);
        cyc(1);
        chk("bad_err_pulse", 64'(err), 64'd0);
        cyc(2);
        chk("bad_no_reads", 64'(ena_cnt - n0), 64'd0);

        // start while busy is ignored
        e0 = err_cnt;
        addr_q.push_back(32'd40); addr_q.push_back(32'd44);
        exp_q.push_back({1'b0, 32'hA000_0028});
        exp_q.push_back({1'b1, 32'hA000_002C});
        issue_start(32'd40, 16'd2);
        issue_start(32'd200, 16'd1);
        wait_idle(50, "busy_start_idle");
        cyc(3);
        chk("busy_start_no_err", 64'(err_cnt - e0), 64'd0);
        chk("busy_start_drained", 64'(exp_q.size()), 64'd0);

        // Abort after the 5th beat
        addr_chk_en = 1'b0;
        d0 = done_cnt;
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 32'hA000_0000 + 32'(4 * k)});
        issue_start(32'd0, 16'd20);                    // N+1
        cyc(6);                                        // N+7
        rdy_man = 1'b0;
        abort = 1'b1;
        cyc(1);                                        // N+8
        abort = 1'b0;
        chk("abort_valid", 64'(m_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_beats", 64'(exp_q.size()), 64'd0);
        n0 = ena_cnt;
        cyc(5);
        chk("abort_no_reads", 64'(ena_cnt - n0), 64'd0);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        rdy_man = 1'b1;
        addr_chk_en = 1'b1;
        addr_q.push_back(32'd8);
        exp_q.push_back({1'b1, 32'hA000_0008});
        issue_start(32'd8, 16'd1);
        wait_idle(50, "post_abort_idle");
        cyc(1);

        // Reset mid-run
        sb_en = 1'b0;
        addr_chk_en = 1'b0;
        issue_start(32'd0, 16'd20);
        cyc(2);
        rsta = 1'b1;
        #1;
        chk("midrst_ena", 64'(bram_ena), 64'd0);
        chk("midrst_stream", 64'({m_valid, m_last, m_data}), 64'd0);
        chk("midrst_status", 64'({busy, done, err}), 64'd0);
        chk("midrst_addr", 64'(bram_addra), 64'd0);
        cyc(2);
        rsta = 1'b0;
        exp_q.delete();
        addr_q.delete();
        sb_en = 1'b1;
        addr_chk_en = 1'b1;
        cyc(1);
        run_basic();

        cyc(3);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
